// File: rtl/game_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl_pkg
// Brief    : Shared state codes, flag width and state type for the Sudoku
//            game-flow controller, its datapath and the display decoder.
// Revision : 1.0 - initial release
// ============================================================================
package game_ctrl_pkg;

   localparam int FLAG_W = 8;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_SET_BOARD = 3'd1;
   localparam state_t ST_SET_DIFF  = 3'd2;
   localparam state_t ST_PLAY      = 3'd3;
   localparam state_t ST_CHECKING  = 3'd4;
   localparam state_t ST_WIN       = 3'd5;
   localparam state_t ST_TRY_AGAIN = 3'd6;
   localparam state_t ST_LOSE      = 3'd7;

   // One-hot phase flag for a state code: bit index equals the code.
   function automatic logic [FLAG_W-1:0] state_flag(input state_t s);
      state_flag    = '0;
      state_flag[s] = 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/game_ctrl_fsm_btn_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_edge
// Brief    : Rising-edge detector for a synchronous button level. A level
//            held high yields exactly one single-cycle pulse.
// Revision : 1.0 - initial release
// ============================================================================
module btn_edge (
   input  logic clka,
   input  logic restart_n,
   input  logic level,
   output logic pulse
);

   logic level_q;
   logic armed_q;

   // Previous level, plus an arm bit so a button already held while reset is
   // released is seen as "already high" rather than as a fresh press.
   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         level_q <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         level_q <= level;
         armed_q <= 1'b1;
      end
   end

   assign pulse = level & ~level_q & armed_q;

endmodule
`default_nettype wire

// File: rtl/game_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl_fsm
// Brief    : Sudoku top-level game-flow controller: board/difficulty setup,
//            play, datapath check handshake with timeout, limited attempts.
//            All outputs are registered (Moore).
// Revision : 1.0 - initial release
// ============================================================================
module game_ctrl_fsm
   import game_ctrl_pkg::*;
#(
   parameter  int MAX_TRIES   = 3,
   parameter  int DIFF_LEVELS = 4,
   parameter  int CHK_TIMEOUT = 255,
   localparam int DW          = (DIFF_LEVELS > 2) ? $clog2(DIFF_LEVELS) : 1,
   localparam int TW          = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1
) (
   input  logic              clka,
   input  logic              restart_n,
   input  logic              restart,
   input  logic              enter,
   input  logic              check,
   input  logic              diff_up,
   input  logic              chk_done,
   input  logic              solved,
   output logic              chk_req,
   output logic [FLAG_W-1:0] flags,
   output logic [2:0]        state,
   output logic [DW-1:0]     difficulty,
   output logic [TW-1:0]     tries_left,
   output logic              chk_timeout
);

   localparam int            TMW        = (CHK_TIMEOUT > 1) ? $clog2(CHK_TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TRIES_INIT = TW'(MAX_TRIES);
   localparam logic [DW-1:0] DIFF_LAST  = DW'(DIFF_LEVELS - 1);
   localparam logic [TMW-1:0] TIMEOUT_AT = TMW'(CHK_TIMEOUT);

   logic enter_p;
   logic check_p;
   logic diff_up_p;

   state_t             state_q,  state_d;
   logic [FLAG_W-1:0]  flags_q;
   logic               chk_req_q;
   logic [DW-1:0]      diff_q,   diff_d;
   logic [TW-1:0]      tries_q,  tries_d;
   logic [TMW-1:0]     timer_q,  timer_d;
   logic               tmo_q,    tmo_d;
   logic               timer_hit;

   btn_edge u_enter_edge (
      .clka      (clka),
      .restart_n (restart_n),
      .level     (enter),
      .pulse     (enter_p)
   );

   btn_edge u_check_edge (
      .clka      (clka),
      .restart_n (restart_n),
      .level     (check),
      .pulse     (check_p)
   );

   btn_edge u_diff_edge (
      .clka      (clka),
      .restart_n (restart_n),
      .level     (diff_up),
      .pulse     (diff_up_p)
   );

   assign timer_hit = (timer_q == TIMEOUT_AT);

   // Next-state function with attempts, difficulty, timer and timeout flag.
   // The timer is zero everywhere except while staying in CHECKING, so entry
   // to CHECKING always starts the count from zero.
   always_comb begin
      state_d = state_q;
      tries_d = tries_q;
      diff_d  = diff_q;
      tmo_d   = tmo_q;
      timer_d = '0;
      if (restart) begin
         state_d = ST_IDLE;
         tries_d = TRIES_INIT;
         tmo_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enter_p) state_d = ST_SET_BOARD;
            end
            ST_SET_BOARD: begin
               if (enter_p) state_d = ST_SET_DIFF;
            end
            ST_SET_DIFF: begin
               // enter takes precedence over a simultaneous diff_up
               if (enter_p) begin
                  state_d = ST_PLAY;
                  tries_d = TRIES_INIT;
               end else if (diff_up_p) begin
                  diff_d = (diff_q == DIFF_LAST) ? '0 : diff_q + DW'(1);
               end
            end
            ST_PLAY: begin
               if (check_p) begin
                  state_d = ST_CHECKING;
                  tmo_d   = 1'b0;
               end
            end
            ST_CHECKING: begin
               timer_d = timer_q + TMW'(1);
               if (chk_done && solved) begin
                  state_d = ST_WIN;
                  timer_d = '0;
               end else if (chk_done || timer_hit) begin
                  // a completion in the timeout cycle is a normal verdict
                  timer_d = '0;
                  tmo_d   = ~chk_done;
                  if (MAX_TRIES == 0) begin
                     state_d = ST_TRY_AGAIN;
                  end else if (tries_q <= TW'(1)) begin
                     state_d = ST_LOSE;
                     tries_d = '0;
                  end else begin
                     state_d = ST_TRY_AGAIN;
                     tries_d = tries_q - TW'(1);
                  end
               end
            end
            ST_WIN, ST_LOSE: begin
               if (enter_p) begin
                  state_d = ST_IDLE;
                  tmo_d   = 1'b0;
               end
            end
            ST_TRY_AGAIN: begin
               if (enter_p) state_d = ST_PLAY;
            end
            default: begin
               state_d = ST_IDLE;
               tmo_d   = 1'b0;
            end
         endcase
      end
   end

   // State, output flags and counters; outputs decode from the next state.
   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         state_q   <= ST_IDLE;
         flags_q   <= state_flag(ST_IDLE);
         chk_req_q <= 1'b0;
         diff_q    <= '0;
         tries_q   <= TRIES_INIT;
         timer_q   <= '0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         flags_q   <= state_flag(state_d);
         chk_req_q <= (state_d == ST_CHECKING);
         diff_q    <= diff_d;
         tries_q   <= tries_d;
         timer_q   <= timer_d;
         tmo_q     <= tmo_d;
      end
   end

   assign state       = state_q;
   assign flags       = flags_q;
   assign chk_req     = chk_req_q;
   assign difficulty  = diff_q;
   assign tries_left  = tries_q;
   assign chk_timeout = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_ctrl_fsm
// Brief    : Scoreboard bench for game_ctrl_fsm. Stimulus queues the expected
//            output tuple and the cycle it must appear; a monitor pops an
//            entry whenever the DUT output tuple changes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_ctrl_fsm;

   logic       clk;
   logic       restart_n, restart, enter, check, diff_up, chk_done, solved;
   logic       chk_req, chk_timeout;
   logic [7:0] flags;
   logic [2:0] state;
   logic [1:0] difficulty, tries_left;

   typedef struct {
      int         id;
      int         cyc;
      logic [2:0] st;
      logic [7:0] fl;
      logic       rq;
      logic [1:0] df;
      logic [1:0] tr;
      logic       tm;
   } exp_t;

   exp_t  exp_q[$];
   int    cyc      = 0;
   int    step_id  = 0;
   int    total    = 0;
   int    bad      = 0;
   logic  done_req = 1'b0;
   logic  first    = 1'b1;
   logic  ended    = 1'b0;
   logic [16:0] cur, prev;
   exp_t  e;

   game_ctrl_fsm #(
      .MAX_TRIES   (3),
      .DIFF_LEVELS (4),
      .CHK_TIMEOUT (15)
   ) dut (
      .clka        (clk),
      .restart_n   (restart_n),
      .restart     (restart),
      .enter       (enter),
      .check       (check),
      .diff_up     (diff_up),
      .chk_done    (chk_done),
      .solved      (solved),
      .chk_req     (chk_req),
      .flags       (flags),
      .state       (state),
      .difficulty  (difficulty),
      .tries_left  (tries_left),
      .chk_timeout (chk_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every change of the output tuple consumes one expectation.
   always @(negedge clk) begin
      if (!ended) begin
         cur = {state, flags, chk_req, difficulty, tries_left, chk_timeout};
         if (first || cur != prev) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_change cyc=%0d got st=%0d fl=%h rq=%b df=%0d tr=%0d tm=%b, required no change",
                        cyc, state, flags, chk_req, difficulty, tries_left, chk_timeout);
            end else begin
               e = exp_q.pop_front();
               if ((e.cyc >= 0 && e.cyc != cyc) || state != e.st || flags != e.fl ||
                   chk_req != e.rq || difficulty != e.df || tries_left != e.tr ||
                   chk_timeout != e.tm) begin
                  bad++;
                  $display("FAIL step%0d got cyc=%0d st=%0d fl=%h rq=%b df=%0d tr=%0d tm=%b, required cyc=%0d st=%0d fl=%h rq=%b df=%0d tr=%0d tm=%b",
                           e.id, cyc, state, flags, chk_req, difficulty, tries_left, chk_timeout,
                           e.cyc, e.st, e.fl, e.rq, e.df, e.tr, e.tm);
               end
            end
         end
         prev  = cur;
         first = 1'b0;
         if (done_req || cyc > 3000) begin
            total++;
            if (cyc > 3000) begin
               bad++;
               $display("FAIL watchdog got cyc=%0d, required end before 3000", cyc);
            end else if (exp_q.size() != 0) begin
               bad++;
               $display("FAIL leftover got %0d pending expectations, required 0 (next step%0d)",
                        exp_q.size(), exp_q[0].id);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            ended = 1'b1;
            $finish;
         end
      end
   end

   task automatic push_exp(input int c, input logic [2:0] st, input logic [7:0] fl,
                           input logic rq, input logic [1:0] df, input logic [1:0] tr,
                           input logic tm);
      exp_t x;
      x.id  = step_id;
      x.cyc = c;
      x.st  = st;
      x.fl  = fl;
      x.rq  = rq;
      x.df  = df;
      x.tr  = tr;
      x.tm  = tm;
      step_id++;
      exp_q.push_back(x);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press_enter();
      enter = 1'b1; tick(); enter = 1'b0; tick();
   endtask

   task automatic press_check();
      check = 1'b1; tick(); check = 1'b0; tick();
   endtask

   task automatic press_diff();
      diff_up = 1'b1; tick(); diff_up = 1'b0; tick();
   endtask

   task automatic pulse_done(input logic sv);
      chk_done = 1'b1; solved = sv; tick(); chk_done = 1'b0; solved = 1'b0; tick();
   endtask

   // Walks IDLE -> SET_BOARD -> SET_DIFF -> PLAY, expecting a fresh tries load.
   task automatic to_play(input logic [1:0] df, input logic [1:0] tr_idle);
      push_exp(cyc + 1, 3'd1, 8'h02, 1'b0, df, tr_idle, 1'b0); press_enter();
      push_exp(cyc + 1, 3'd2, 8'h04, 1'b0, df, tr_idle, 1'b0); press_enter();
      push_exp(cyc + 1, 3'd3, 8'h08, 1'b0, df, 2'd3,    1'b0); press_enter();
   endtask

   initial begin
      int e2;
      restart_n = 1'b1; restart = 1'b0; enter = 1'b0; check = 1'b0;
      diff_up = 1'b0; chk_done = 1'b0; solved = 1'b0;

      // reset values
      push_exp(-1, 3'd0, 8'h01, 1'b0, 2'd0, 2'd3, 1'b0);
      #2 restart_n = 1'b0;
      repeat (3) tick();
      restart_n = 1'b1;
      repeat (2) tick();

      // 1: enter x3 walks to PLAY
      to_play(2'd0, 2'd3);

      // 2: soft restart back to IDLE, then difficulty wrap in SET_DIFF
      push_exp(cyc + 1, 3'd0, 8'h01, 1'b0, 2'd0, 2'd3, 1'b0);
      restart = 1'b1; tick(); restart = 1'b0; tick();
      push_exp(cyc + 1, 3'd1, 8'h02, 1'b0, 2'd0, 2'd3, 1'b0); press_enter();
      push_exp(cyc + 1, 3'd2, 8'h04, 1'b0, 2'd0, 2'd3, 1'b0); press_enter();
      push_exp(cyc + 1, 3'd2, 8'h04, 1'b0, 2'd1, 2'd3, 1'b0); press_diff();
      push_exp(cyc + 1, 3'd2, 8'h04, 1'b0, 2'd2, 2'd3, 1'b0); press_diff();
      push_exp(cyc + 1, 3'd2, 8'h04, 1'b0, 2'd3, 2'd3, 1'b0); press_diff();
      push_exp(cyc + 1, 3'd2, 8'h04, 1'b0, 2'd0, 2'd3, 1'b0); press_diff();
      push_exp(cyc + 1, 3'd2, 8'h04, 1'b0, 2'd1, 2'd3, 1'b0); press_diff();
      push_exp(cyc + 1, 3'd3, 8'h08, 1'b0, 2'd1, 2'd3, 1'b0);
      enter = 1'b1; diff_up = 1'b1; tick(); enter = 1'b0; diff_up = 1'b0; tick();

      // 3: check, solved after ~10 cycles -> WIN, enter -> IDLE
      push_exp(cyc + 1, 3'd4, 8'h10, 1'b1, 2'd1, 2'd3, 1'b0); press_check();
      repeat (8) tick();
      push_exp(cyc + 1, 3'd5, 8'h20, 1'b0, 2'd1, 2'd3, 1'b0); pulse_done(1'b1);
      push_exp(cyc + 1, 3'd0, 8'h01, 1'b0, 2'd1, 2'd3, 1'b0); press_enter();

      // 4: three failed checks -> TRY_AGAIN, TRY_AGAIN, LOSE
      to_play(2'd1, 2'd3);
      pulse_done(1'b1);  // chk_done outside CHECKING must not move anything
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            push_exp(cyc + 1, 3'd3, 8'h08, 1'b0, 2'd1, 2'(3 - k), 1'b0); press_enter();
         end
         push_exp(cyc + 1, 3'd4, 8'h10, 1'b1, 2'd1, 2'(3 - k), 1'b0); press_check();
         tick();
         if (k < 2) push_exp(cyc + 1, 3'd6, 8'h40, 1'b0, 2'd1, 2'(2 - k), 1'b0);
         else       push_exp(cyc + 1, 3'd7, 8'h80, 1'b0, 2'd1, 2'd0, 1'b0);
         pulse_done(1'b0);
      end
      push_exp(cyc + 1, 3'd0, 8'h01, 1'b0, 2'd1, 2'd0, 1'b0); press_enter();

      // 5: timeout 16 cycles after entry, then chk_done exactly at timer==15
      to_play(2'd1, 2'd0);
      push_exp(cyc + 1,  3'd4, 8'h10, 1'b1, 2'd1, 2'd3, 1'b0);
      push_exp(cyc + 17, 3'd6, 8'h40, 1'b0, 2'd1, 2'd2, 1'b1);
      press_check();
      repeat (18) tick();
      push_exp(cyc + 1, 3'd3, 8'h08, 1'b0, 2'd1, 2'd2, 1'b1); press_enter();
      e2 = cyc + 1;
      push_exp(e2, 3'd4, 8'h10, 1'b1, 2'd1, 2'd2, 1'b0); press_check();
      while (cyc < e2 + 15) tick();
      push_exp(e2 + 16, 3'd5, 8'h20, 1'b0, 2'd1, 2'd2, 1'b0); pulse_done(1'b1);

      // 6: soft restart mid-CHECKING, async reset mid-PLAY, held enter
      push_exp(cyc + 1, 3'd0, 8'h01, 1'b0, 2'd1, 2'd2, 1'b0); press_enter();
      to_play(2'd1, 2'd2);
      push_exp(cyc + 1, 3'd4, 8'h10, 1'b1, 2'd1, 2'd3, 1'b0); press_check();
      repeat (3) tick();
      push_exp(cyc + 1, 3'd0, 8'h01, 1'b0, 2'd1, 2'd3, 1'b0);
      restart = 1'b1; tick(); restart = 1'b0; tick();
      to_play(2'd1, 2'd3);
      push_exp(cyc, 3'd0, 8'h01, 1'b0, 2'd0, 2'd3, 1'b0);
      restart_n = 1'b0; enter = 1'b1;
      repeat (2) tick();
      restart_n = 1'b1;
      repeat (4) tick();
      enter = 1'b0;
      repeat (2) tick();
      push_exp(cyc + 1, 3'd1, 8'h02, 1'b0, 2'd0, 2'd3, 1'b0); press_enter();

      repeat (2) tick();
      done_req = 1'b1;
   end

endmodule
`default_nettype wire
